// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: routes one ready/valid input stream to one of N output
// channels (or all of them on broadcast). Each channel has a one-entry
// holding register. A full channel whose sink is ready in the same cycle can
// accept a new beat, so a ready target sustains one beat per cycle.
// Out-of-range selects are accepted and dropped, and they set a sticky error
// flag. Every accepted beat is counted.
module stream_demux_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               err_oor,
    input  logic               clr_err,
    output logic [15:0]        xfer_cnt
);

    logic [N-1:0]            valid_q, valid_d;
    logic [N-1:0][WIDTH-1:0] data_q, data_d;
    logic                    err_q, err_d;
    logic [15:0]             xfer_cnt_q, xfer_cnt_d;

    logic [N-1:0]            free;
    logic [N-1:0]            sel_hit;
    logic [N-1:0]            load;
    logic                    sel_in_range;
    logic                    accept;

    // One-hot decode of in_sel; no bit is set for selects past N-1
    always_comb begin
        sel_hit = '0;
        for (int unsigned c = 0; c < N; c++) begin
            sel_hit[c] = (in_sel == SEL_W'(c));
        end
        sel_in_range = |sel_hit;
    end

    // A channel is free when it is empty or is being drained this cycle
    // (in_valid is deliberately not used here)
    always_comb begin
        free = ~valid_q | out_ready;
        if (bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = |(free & sel_hit);
        end else begin
            in_ready = 1'b1;
        end
    end

    // Next state: channel loads, drains, sticky error and transfer count
    always_comb begin
        accept = in_valid && in_ready;

        load = '0;
        if (accept) begin
            load = bcast ? {N{1'b1}} : sel_hit;
        end

        // A load wins over a drain, so a full channel with a ready sink stays valid
        valid_d = load | (valid_q & ~out_ready);

        data_d = data_q;
        for (int unsigned c = 0; c < N; c++) begin
            if (load[c]) begin
                data_d[c] = in_data;
            end
        end

        // A new out-of-range drop overrides a coincident clear
        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (accept && !bcast && !sel_in_range) begin
            err_d = 1'b1;
        end

        xfer_cnt_d = accept ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_oor   = err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed vector table and corner sequences on an
// N=4 instance and an N=3 instance, then randomized traffic checked against a
// per-channel holding-slot reference model.
module tb_stream_demux_1xn;

    logic clk;
    logic rst_n;

    // N=4 instance signals
    logic        v4, rdy4, bc4, err4, clr4;
    logic [7:0]  dat4;
    logic [1:0]  sel4;
    logic [3:0]  ov4, ordy4;
    logic [31:0] od4;
    logic [15:0] cnt4;

    // N=3 instance signals
    logic        v3, rdy3, bc3, err3, clr3;
    logic [7:0]  dat3;
    logic [1:0]  sel3;
    logic [2:0]  ov3, ordy3;
    logic [23:0] od3;
    logic [15:0] cnt3;

    int total;
    int bad;

    stream_demux_1xn #(.WIDTH(8), .N(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .in_data(dat4), .in_sel(sel4), .bcast(bc4), .out_valid(ov4),
        .out_ready(ordy4), .out_data(od4), .err_oor(err4), .clr_err(clr4),
        .xfer_cnt(cnt4)
    );

    stream_demux_1xn #(.WIDTH(8), .N(3)) d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
        .in_data(dat3), .in_sel(sel3), .bcast(bc3), .out_valid(ov3),
        .out_ready(ordy3), .out_data(od3), .err_oor(err3), .clr_err(clr3),
        .xfer_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is a single slot: present flag plus last data written.
    logic       mv   [2][4];
    logic [7:0] md   [2][4];
    logic       merr [2];
    logic [15:0] mcnt[2];

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                mv[k][c] = 1'b0;
                md[k][c] = 8'h00;
            end
            merr[k] = 1'b0;
            mcnt[k] = 16'd0;
        end
    endtask

    function automatic logic m_ready(input int k, input int n, input int sel,
                                     input logic bc, input logic [3:0] ordy);
        logic r;
        r = 1'b1;
        if (bc) begin
            for (int c = 0; c < n; c++)
                if (mv[k][c] && !ordy[c]) r = 1'b0;
        end else if (sel < n) begin
            r = !mv[k][sel] || ordy[sel];
        end
        return r;
    endfunction

    task automatic m_step(input int k, input int n, input logic v, input int sel,
                          input logic bc, input logic [7:0] d, input logic [3:0] ordy,
                          input logic clr);
        logic acc;
        acc = v && m_ready(k, n, sel, bc, ordy);
        for (int c = 0; c < n; c++) begin
            if (acc && (bc || sel == c)) begin
                mv[k][c] = 1'b1;
                md[k][c] = d;
            end else if (mv[k][c] && ordy[c]) begin
                mv[k][c] = 1'b0;
            end
        end
        if (acc && !bc && sel >= n) merr[k] = 1'b1;
        else if (clr)               merr[k] = 1'b0;
        if (acc) mcnt[k] = mcnt[k] + 16'd1;
    endtask

    function automatic logic [63:0] m_ov(input int k, input int n);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < n; c++) r[c] = mv[k][c];
        return r;
    endfunction

    function automatic logic [63:0] m_od(input int k, input int n);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < n; c++) r[c*8 +: 8] = md[k][c];
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        v4 = 0; sel4 = 0; bc4 = 0; dat4 = 0; ordy4 = 4'hF; clr4 = 0;
        v3 = 0; sel3 = 0; bc3 = 0; dat3 = 0; ordy3 = 3'h7; clr3 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        bc;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [31:0] e_od;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Unicast 0xA0..0xA3 to channels 0..3, all sinks ready
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 32'h000000A0, 16'd1};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'hA1, 4'b1111, 1'b1, 4'b0010, 32'h0000A1A0, 16'd2};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hA2, 4'b1111, 1'b1, 4'b0100, 32'h00A2A1A0, 16'd3};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 8'hA3, 4'b1111, 1'b1, 4'b1000, 32'hA3A2A1A0, 16'd4};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA3A2A1A0, 16'd4};
        // Channel 2 stalled: first beat held, second refused until sink ready
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 8'h11, 4'b1011, 1'b1, 4'b0100, 32'hA311A1A0, 16'd5};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'b1011, 1'b0, 4'b0100, 32'hA311A1A0, 16'd5};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'b1111, 1'b1, 4'b0100, 32'hA322A1A0, 16'd6};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA322A1A0, 16'd6};
        // Broadcast into empty channels, then broadcast blocked by stalled channel 1
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 8'h5C, 4'b1111, 1'b1, 4'b1111, 32'h5C5C5C5C, 16'd7};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1101, 1'b1, 4'b0010, 32'h5C5C5C5C, 16'd7};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 8'h77, 4'b1101, 1'b0, 4'b0010, 32'h5C5C5C5C, 16'd7};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 8'h77, 4'b1101, 1'b0, 4'b0010, 32'h5C5C5C5C, 16'd7};
        tbl[13] = '{1'b1, 2'd0, 1'b1, 8'h77, 4'b1111, 1'b1, 4'b1111, 32'h77777777, 16'd8};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h77777777, 16'd8};

        // Reset values
        #3;
        chk("reset_ov4", 64'(ov4), 64'h0);
        chk("reset_od4", 64'(od4), 64'h0);
        chk("reset_cnt4", 64'(cnt4), 64'h0);
        chk("reset_err4", 64'(err4), 64'h0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            v4 = tbl[i].v; sel4 = tbl[i].sel; bc4 = tbl[i].bc;
            dat4 = tbl[i].d; ordy4 = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 64'(rdy4), 64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 64'(ov4), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 64'(od4), 64'(tbl[i].e_od));
            chk($sformatf("tbl%0d_xfer_cnt", i), 64'(cnt4), 64'(tbl[i].e_cnt));
        end
        chk("tbl_err4_clear", 64'(err4), 64'h0);

        // ---------------- N=3 out-of-range select ----------------
        do_reset();
        v3 = 1; sel3 = 2'd3; dat3 = 8'h99; ordy3 = 3'b111;
        @(negedge clk);
        chk("oor_in_ready", 64'(rdy3), 64'h1);
        @(posedge clk); #1;
        chk("oor_out_valid", 64'(ov3), 64'h0);
        chk("oor_err_set", 64'(err3), 64'h1);
        chk("oor_cnt", 64'(cnt3), 64'h1);
        v3 = 0;
        @(posedge clk); #1;
        chk("oor_err_sticky", 64'(err3), 64'h1);
        clr3 = 1;
        @(posedge clk); #1;
        chk("oor_err_cleared", 64'(err3), 64'h0);
        v3 = 1; sel3 = 2'd3; clr3 = 1;
        @(posedge clk); #1;
        chk("oor_clr_coincide", 64'(err3), 64'h1);
        chk("oor_cnt2", 64'(cnt3), 64'h2);
        clr3 = 0; sel3 = 2'd2; dat3 = 8'h33;
        @(posedge clk); #1;
        chk("n3_sel2_valid", 64'(ov3), 64'h4);
        chk("n3_sel2_data", 64'(od3[23:16]), 64'h33);
        v3 = 0;

        // ---------------- mid-clock asynchronous reset ----------------
        v4 = 1; bc4 = 1; dat4 = 8'hE1; ordy4 = 4'b0000;
        v3 = 1; bc3 = 0; sel3 = 2'd3;
        @(posedge clk); #1;
        v4 = 0; v3 = 0;
        chk("prefill_ov4", 64'(ov4), 64'hF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ov4", 64'(ov4), 64'h0);
        chk("async_rst_od4", 64'(od4), 64'h0);
        chk("async_rst_cnt4", 64'(cnt4), 64'h0);
        chk("async_rst_err3", 64'(err3), 64'h0);
        chk("async_rst_cnt3", 64'(cnt3), 64'h0);
        bc4 = 1; bc3 = 0; sel3 = 2'd3;
        #1;
        chk("rst_ready_bcast", 64'(rdy4), 64'h1);
        chk("rst_ready_oor", 64'(rdy3), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        v4 = 1; sel4 = 2'd1; dat4 = 8'h42; ordy4 = 4'hF;
        @(posedge clk); #1;
        v4 = 0;
        chk("post_rst_ov", 64'(ov4), 64'h2);
        chk("post_rst_od", 64'(od4), 64'h00004200);
        chk("post_rst_cnt", 64'(cnt4), 64'h1);

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v4 = 1'($urandom_range(0, 3) != 0);
            sel4 = 2'($urandom_range(0, 3));
            bc4 = 1'($urandom_range(0, 5) == 0);
            dat4 = 8'($urandom);
            for (int c = 0; c < 4; c++) ordy4[c] = 1'($urandom_range(0, 3) != 0);
            clr4 = 1'($urandom_range(0, 7) == 0);
            v3 = 1'($urandom_range(0, 3) != 0);
            sel3 = 2'($urandom_range(0, 3));
            bc3 = 1'($urandom_range(0, 5) == 0);
            dat3 = 8'($urandom);
            for (int c = 0; c < 3; c++) ordy3[c] = 1'($urandom_range(0, 3) != 0);
            clr3 = 1'($urandom_range(0, 7) == 0);
            @(negedge clk);
            chk("rnd_rdy4", 64'(rdy4), 64'(m_ready(0, 4, int'(sel4), bc4, ordy4)));
            chk("rnd_rdy3", 64'(rdy3), 64'(m_ready(1, 3, int'(sel3), bc3, {1'b0, ordy3})));
            @(posedge clk);
            m_step(0, 4, v4, int'(sel4), bc4, dat4, ordy4, clr4);
            m_step(1, 3, v3, int'(sel3), bc3, dat3, {1'b0, ordy3}, clr3);
            #1;
            chk("rnd_ov4", 64'(ov4), m_ov(0, 4));
            chk("rnd_od4", 64'(od4), m_od(0, 4));
            chk("rnd_err4", 64'(err4), 64'(merr[0]));
            chk("rnd_cnt4", 64'(cnt4), 64'(mcnt[0]));
            chk("rnd_ov3", 64'(ov3), m_ov(1, 3));
            chk("rnd_od3", 64'(od3), m_od(1, 3));
            chk("rnd_err3", 64'(err3), 64'(merr[1]));
            chk("rnd_cnt3", 64'(cnt3), 64'(mcnt[1]));
        end

        // ---------------- counter wrap ----------------
        do_reset();
        v4 = 1; sel4 = 2'd0; bc4 = 0; ordy4 = 4'hF;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_at_ffff", 64'(cnt4), 64'hFFFF);
        @(posedge clk); #1;
        chk("cnt_wrap", 64'(cnt4), 64'h0);
        v4 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1xn.md
STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width per channel in bits (WIDTH>=1).
REQ-002 Parameter N, default 4, sets the output channel count (2<=N<=16).
REQ-003 Parameter SEL_W, default $clog2(N), sets the select width; it is derived and never overridden.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-006 Port in_valid, input, 1 bit: the source offers a beat.
REQ-007 Port in_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-008 Port in_data, input, WIDTH bits: the beat payload.
REQ-009 Port in_sel, input, SEL_W bits: the destination channel index, sampled with the beat.
REQ-010 Port bcast, input, 1 bit: when 1, route the beat to all N channels and ignore in_sel.
REQ-011 Port out_valid, output, N bits: bit c indicates that channel c holds a beat.
REQ-012 Port out_ready, input, N bits: bit c indicates that the sink of channel c takes the beat.
REQ-013 Port out_data, output, N*WIDTH bits: channel c drives bits [c*WIDTH +: WIDTH].
REQ-014 Port err_oor, output, 1 bit: sticky flag for an out-of-range select.
REQ-015 Port clr_err, input, 1 bit: synchronous clear of err_oor.
REQ-016 Port xfer_cnt, output, 16 bits: count of accepted input beats.

Function
REQ-017 Each channel c SHALL own one holding register (valid_q[c], data_q[c]) with out_valid[c]=valid_q[c] and out_data slice c = data_q[c].
REQ-018 free(c) SHALL be defined as !valid_q[c] || out_ready[c] (pass-through drain in the same cycle).
REQ-019 in_ready SHALL be &free[N-1:0] when bcast=1, free(in_sel) when bcast=0 and in_sel<N, and 1 when bcast=0 and in_sel>=N.
REQ-020 in_ready SHALL depend only on state, bcast, in_sel and out_ready, never on in_valid.
REQ-021 An accept SHALL be defined as in_valid && in_ready at a rising clk edge.
REQ-022 A unicast accept SHALL load data_q[in_sel]<=in_data and valid_q[in_sel]<=1; other channels are unaffected by the load.
REQ-023 A broadcast accept SHALL load every data_q with in_data and set every valid_q.
REQ-024 When valid_q[c]=1, out_ready[c]=1 and there is no load into c, valid_q[c] SHALL go to 0; when load and drain coincide, valid_q[c] SHALL stay 1 with the new data.
REQ-025 When valid_q[c]=1 and out_ready[c]=0, data_q[c] SHALL remain stable.
REQ-026 Latency SHALL be exactly 1 cycle from accept to out_valid, with sustained throughput of 1 beat/cycle when the target is ready.
REQ-027 A unicast accept with in_sel>=N (possible only when N is not a power of 2) SHALL drop the beat and set err_oor<=1.
REQ-028 err_oor SHALL stay 1 until clr_err=1; when clr_err and a new out-of-range accept coincide, err_oor SHALL be 1.
REQ-029 xfer_cnt SHALL increment by 1 on every accept (unicast, broadcast or dropped) and wrap from 16'hFFFF to 0.

Reset
REQ-030 While rst_n=0, valid_q SHALL be all 0, data_q all 0, err_oor 0 and xfer_cnt 0, taking effect immediately without a clock.
REQ-031 During reset, in_ready SHALL be 1 except when bcast=0 with in_sel>=N, where it is also 1.
REQ-032 Reset asserted mid-stream SHALL discard all held beats; the first accept after rst_n rises SHALL behave as from a fresh state.

Verification
REQ-033 With N=4, WIDTH=8, all out_ready=1 and unicast beats 0xA0..0xA3 to sel 0..3 on consecutive cycles, each out_valid[c] SHALL pulse 1 cycle later with data 0xA0+c, and xfer_cnt SHALL reach 4.
REQ-034 With out_ready[2]=0, two beats to sel 2 SHALL give: the first held (0x11 stable), in_ready=0 on the second, and the second loaded in the cycle after out_ready[2]=1.
REQ-035 With bcast=1, in_data=0x5C and all channels empty, out_valid SHALL be 4'b1111 and all slices 0x5C; with channel 1 stalled full, a second broadcast SHALL have in_ready=0 until it drains.
REQ-036 With N=3 and sel=3, the beat SHALL be accepted and dropped, out_valid SHALL stay 0, err_oor SHALL be 1 and persist, and clr_err SHALL clear it the next cycle.
REQ-037 Asserting rst_n=0 mid-clock with channels full SHALL clear out_valid, err_oor and xfer_cnt asynchronously.
REQ-038 Preloading xfer_cnt to 0xFFFF and issuing one accept SHALL give xfer_cnt=0.
